// File: rtl/box_filter_2x2.sv
// 2x2 box filter over a raster pixel stream with edge clamping.
// One previous-row line buffer plus two window registers; single registered output stage.
module box_filter_2x2 #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        data_in_valid,
   input  logic [15:0] data_in_data,
   output logic        data_in_ready,
   output logic        data_out_valid,
   output logic [15:0] data_out_data,
   input  logic        data_out_ready
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   logic [XW-1:0] x_reg, x_next;
   logic [YW-1:0] y_reg, y_next;
   logic [15:0]   left_reg;
   logic [15:0]   diag_reg;
   logic [15:0]   out_data_reg, out_data_next;
   logic          out_valid_reg, out_valid_next;
   logic [15:0]   line_buf [WIDTH];

   logic          accept;
   logic [15:0]   above;
   logic [15:0]   term_b, term_c, term_d;
   logic [17:0]   sum;

   assign data_in_ready  = ~out_valid_reg | data_out_ready;
   assign accept         = data_in_valid & data_in_ready;
   assign data_out_valid = out_valid_reg;
   assign data_out_data  = out_data_reg;

   // Previous-row value for this column, read before this cycle's write lands.
   assign above = line_buf[x_reg];

   always_comb begin
      term_b = (x_reg == '0) ? data_in_data : left_reg;
      term_c = (y_reg == '0) ? data_in_data : above;
      // Left column reuses the (already clamped) upper term; top row reuses the left term.
      if (x_reg == '0)
         term_d = term_c;
      else if (y_reg == '0)
         term_d = term_b;
      else
         term_d = diag_reg;
      sum = 18'(data_in_data) + 18'(term_b) + 18'(term_c) + 18'(term_d);
   end

   always_comb begin
      x_next         = x_reg;
      y_next         = y_reg;
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      if (accept) begin
         out_data_next  = sum[17:2];
         out_valid_next = 1'b1;
         if (x_reg == X_LAST) begin
            x_next = '0;
            y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
         end else begin
            x_next = x_reg + 1'b1;
         end
      end else if (data_out_ready) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         x_reg         <= '0;
         y_reg         <= '0;
         left_reg      <= '0;
         diag_reg      <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         x_reg         <= x_next;
         y_reg         <= y_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         if (accept) begin
            left_reg <= data_in_data;
            diag_reg <= term_c;
         end
      end
   end

   // Contents need no reset: row 0 never consults the buffer.
   always_ff @(posedge CLK) begin
      if (accept && !RESET)
         line_buf[x_reg] <= data_in_data;
   end

endmodule

// File: tb/tb_box_filter_2x2.sv
// Scoreboard bench for box_filter_2x2: a frame-image model pushes expected outputs on
// each accept; outputs are popped and compared on each output transfer.
module tb_box_filter_2x2;

   localparam int W = 32;
   localparam int H = 32;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        data_in_valid;
   logic [15:0] data_in_data;
   logic        data_in_ready;
   logic        data_out_valid;
   logic [15:0] data_out_data;
   logic        data_out_ready;

   box_filter_2x2 #(.WIDTH(W), .HEIGHT(H)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .data_in_valid  (data_in_valid),
      .data_in_data   (data_in_data),
      .data_in_ready  (data_in_ready),
      .data_out_valid (data_out_valid),
      .data_out_data  (data_out_data),
      .data_out_ready (data_out_ready)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] exp;
      int          x;
      int          y;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   logic [15:0] img [H][W];
   int          tb_x, tb_y;
   int          checks, failures;
   int          spot_x, spot_y;
   logic [15:0] spot_val;
   bit          spot_en;
   bit          prev_acc, prev_xfer;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pix(input int mode, input logic [15:0] val);
      case (mode)
         1:       return 16'(4 * tb_x);
         2:       return (tb_y == 0) ? 16'd1 : 16'd3;
         default: return val;
      endcase
   endfunction

   // One clock: drive, sample at negedge, score, then move to just after the next posedge.
   task automatic step(input logic vin, input logic [15:0] din, input logic ordy, output bit acc);
      sb_entry_t e;
      int xm, ym, s;
      data_in_valid  = vin;
      data_in_data   = din;
      data_out_ready = ordy;
      @(negedge CLK);
      if (prev_acc)
         check("latency_valid", data_out_valid, 1);
      else if (prev_xfer)
         check("valid_fall", data_out_valid, 0);
      acc = vin && data_in_ready;
      if (data_out_valid && ordy) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("out(%0d,%0d)", e.x, e.y), data_out_data, e.exp);
            if (spot_en && e.x == spot_x && e.y == spot_y)
               check($sformatf("spot(%0d,%0d)", e.x, e.y), data_out_data, spot_val);
         end
      end
      if (acc) begin
         img[tb_y][tb_x] = din;
         xm = (tb_x == 0) ? 0 : tb_x - 1;
         ym = (tb_y == 0) ? 0 : tb_y - 1;
         s = int'(img[tb_y][tb_x]) + int'(img[tb_y][xm]) + int'(img[ym][tb_x]) + int'(img[ym][xm]);
         e.exp = 16'(s >> 2);
         e.x = tb_x;
         e.y = tb_y;
         sb_q.push_back(e);
         tb_x++;
         if (tb_x == W) begin
            tb_x = 0;
            tb_y = (tb_y == H - 1) ? 0 : tb_y + 1;
         end
      end
      prev_acc  = acc;
      prev_xfer = data_out_valid && ordy;
      @(posedge CLK);
      #1;
   endtask

   task automatic run(input int n, input int mode, input logic [15:0] val, input bit gaps);
      int got, budget;
      bit acc, vin, ordy;
      got = 0;
      budget = n * 10 + 100;
      while (got < n && budget > 0) begin
         vin  = gaps ? ($urandom_range(3) != 0) : 1'b1;
         ordy = gaps ? ($urandom_range(3) != 0) : 1'b1;
         step(vin, pix(mode, val), ordy, acc);
         if (acc) got++;
         budget--;
      end
      if (got < n) check("run_timeout", got, n);
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1, acc);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      data_in_valid = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      data_out_ready = 1'b0;
      sb_q.delete();
      tb_x = 0;
      tb_y = 0;
      prev_acc = 0;
      prev_xfer = 0;
      #1;
      check("rst_out_valid", data_out_valid, 0);
      check("rst_out_data", data_out_data, 0);
      check("rst_in_ready", data_in_ready, 1);
   endtask

   initial begin
      bit acc;
      int n_acc;
      logic [15:0] held;
      checks = 0;
      failures = 0;
      spot_en = 0;
      RESET = 1'b1;
      data_in_valid = 1'b0;
      data_in_data = '0;
      data_out_ready = 1'b1;
      foreach (img[i, j]) img[i][j] = '0;
      repeat (2) @(posedge CLK);
      #1;
      do_reset();

      // Constant frame at full throughput.
      run(W * H, 0, 16'd100, 0);
      // Ramp frame with random gaps on both sides.
      spot_en = 1; spot_x = 5; spot_y = 3; spot_val = 16'd18;
      run(W * H, 1, 16'd0, 1);
      spot_en = 0;
      // Saturated frame: no overflow.
      run(W * H, 0, 16'hFFFF, 1);
      drain();

      // Row 0 = 1, later rows = 3.
      do_reset();
      spot_en = 1; spot_x = 1; spot_y = 1; spot_val = 16'd2;
      run(2 * W, 2, 16'd0, 0);
      spot_en = 0;
      drain();

      // Backpressure from idle: one accept, then ready held low with stable output.
      n_acc = 0;
      step(1'b1, pix(2, 16'd0), 1'b0, acc);
      if (acc) n_acc++;
      held = data_out_data;
      for (int i = 0; i < 5; i++) begin
         check("bp_ready_low", data_in_ready, 0);
         check("bp_data_stable", data_out_data, held);
         step(1'b1, pix(2, 16'd0), 1'b0, acc);
         if (acc) n_acc++;
      end
      check("bp_accept_count", n_acc, 1);
      run(W - 3, 2, 16'd0, 1);
      drain();
      check("bp_sb_empty", sb_q.size(), 0);

      // Reset mid-frame with an output held, then a fresh constant frame.
      do_reset();
      run(40, 0, 16'd3, 1);
      step(1'b1, 16'd3, 1'b0, acc);
      step(1'b1, 16'd3, 1'b0, acc);
      do_reset();
      spot_en = 1; spot_x = 0; spot_y = 0; spot_val = 16'd7;
      run(W * H, 0, 16'd7, 1);
      spot_en = 0;

      // Back-to-back frames: frame 1 row 0 must ignore frame 0's last row.
      run(W * H, 0, 16'd50, 0);
      spot_en = 1; spot_x = 3; spot_y = 0; spot_val = 16'd10;
      run(W * H, 0, 16'd10, 0);
      spot_en = 0;
      drain();
      check("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
